hub_link_bridge: RTL and testbench
==================================

HUB_LINK_BRIDGE -- requirements
Module: hub_link_bridge

Interface
REQ-001 The block SHALL have parameter HUB_FIFO_PHYSICAL_WIDTH, default 64, giving the width of one hub message word.
REQ-002 The block SHALL have parameter LINK_FIFO_DEPTH, default 4, giving the words buffered per direction; it is a power of two and at least 2.
REQ-003 Port clk, input, 1: the single clock.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Ports hub_tx_data (input, W), hub_tx_valid (input, 1), hub_tx_ready (output, 1): words from one root-hub downstream FIFO lane toward the leaf.
REQ-006 Ports leaf_tx_data (output, W), leaf_tx_valid (output, 1), leaf_tx_ready (input, 1): words toward the leaf hub.
REQ-007 Ports leaf_rx_data (input, W), leaf_rx_valid (input, 1), leaf_rx_ready (output, 1): words from the leaf hub.
REQ-008 Ports hub_rx_data (output, W), hub_rx_valid (output, 1), hub_rx_ready (input, 1): words toward the root-hub downstream input lane.
REQ-009 Ports leaf_has_message_flying and leaf_has_odd_clusters: inputs, 1 bit each, carrying the leaf status.
REQ-010 Ports hub_has_message_flying and hub_has_odd_clusters: outputs, 1 bit each, carrying the status presented to the hub.
REQ-011 In this list, W means HUB_FIFO_PHYSICAL_WIDTH.

Function
REQ-012 Each direction (tx: hub to leaf; rx: leaf to hub) SHALL be an independent first-in, first-out buffer of LINK_FIFO_DEPTH words.
REQ-013 A word transfers on a rising clk edge when valid and ready are both 1.
REQ-014 The occupancy count width SHALL be $clog2(LINK_FIFO_DEPTH+1).
REQ-015 The read and write pointers SHALL be $clog2(LINK_FIFO_DEPTH) bits and wrap modulo the depth.
REQ-016 Input-side ready SHALL equal NOT full, taken from registered occupancy only, with no combinational path from the output-side ready.
REQ-017 Output-side valid SHALL equal NOT empty; output data SHALL be the head word and SHALL stay stable while valid is 1 and ready is 0.
REQ-018 A word accepted on edge N SHALL be presented at the output after edge N, giving 1-cycle latency.
REQ-019 Simultaneous push and pop when neither full nor empty SHALL leave the occupancy unchanged and preserve order.
REQ-020 When full, ready is 0, so no push occurs even if a pop happens in the same cycle.
REQ-021 When empty, valid is 0, so no pop occurs.
REQ-022 leaf_has_message_flying and leaf_has_odd_clusters SHALL each be captured in one register stage (flag_ff).
REQ-023 hub_has_odd_clusters SHALL equal the leaf_has_odd_clusters register.
REQ-024 hub_has_message_flying SHALL be the OR of: the leaf_has_message_flying register, tx not empty, rx not empty, hub_tx_valid, and leaf_rx_valid.
REQ-025 As a result of REQ-024, the stage controller never observes quiescence while a word is inside or entering the bridge.
REQ-026 A drain-hold counter (2 bits) SHALL reload to 2 whenever the REQ-024 OR term is 1 and otherwise decrement to 0.
REQ-027 hub_has_message_flying SHALL be 1 while the drain-hold counter is nonzero, covering the registered-flag lag after the last word leaves.
REQ-028 Data words SHALL pass through unmodified; no width conversion and no inspection of contents.

Reset
REQ-029 On reset assertion, all pointers, occupancies, flag registers and the drain-hold counter SHALL clear asynchronously.
REQ-030 During and after reset: hub_tx_ready=1, leaf_rx_ready=1, leaf_tx_valid=0, hub_rx_valid=0, hub_has_message_flying=0, hub_has_odd_clusters=0.
REQ-031 Reset asserted mid-operation SHALL discard buffered words; no partial word is ever emitted afterwards.
REQ-032 Data outputs are don't-care while the matching valid is 0.

Configuration
REQ-033 Macro HUB_LINK_STATS_EN SHALL control an optional statistics feature.
REQ-034 When HUB_LINK_STATS_EN is defined, the block SHALL add 32-bit outputs tx_word_count and rx_word_count, incremented on each leaf_tx and hub_rx transfer respectively.
REQ-035 tx_word_count and rx_word_count SHALL saturate at 32'hFFFFFFFF and reset to 0.
REQ-036 When HUB_LINK_STATS_EN is undefined, the ports and counters SHALL not exist and behaviour SHALL be otherwise identical.

Structure
REQ-037 Package hub_link_pkg SHALL hold the default HUB_FIFO_PHYSICAL_WIDTH, the default LINK_FIFO_DEPTH and the drain-hold reload constant (2).
REQ-038 Sub-module link_fifo SHALL implement one direction (parameterised by width and depth) and SHALL be instantiated twice.
REQ-039 Status flag logic and the drain-hold counter SHALL stay in hub_link_bridge.

Verification
REQ-040 Single word: push 64'h0000_0000_DEAD_BEEF on hub_tx with leaf_tx_ready=1 -> leaf_tx_valid=1 with that data exactly 1 cycle later; hub_has_message_flying=1 from the push cycle until 2 cycles after the word leaves.
REQ-041 Full: with leaf_tx_ready=0, push 4 words -> hub_tx_ready=0 after the 4th; a 5th valid is not accepted; release ready -> 4 words emerge in order, 1 per cycle.
REQ-042 Simultaneous push and pop with occupancy 2 for 10 cycles -> occupancy stays 2 and the output sequence equals the input sequence.
REQ-043 Status: set leaf_has_odd_clusters=1 -> hub_has_odd_clusters=1 after exactly 1 edge; set leaf_has_message_flying=0 with buffers empty -> hub_has_message_flying falls within 3 cycles.
REQ-044 Reset mid-burst with 3 words buffered in rx -> hub_rx_valid=0 immediately; after reset release no stale word appears.
REQ-045 With HUB_LINK_STATS_EN, 7 tx transfers and 5 rx transfers -> tx_word_count=7 and rx_word_count=5.

Source files
------------

// File: rtl/hub_link_pkg.sv
// Shared defaults for the hub/leaf link bridge: word width, per-direction depth
// and the drain-hold reload value that stretches message-flying after the last word.
package hub_link_pkg;
   localparam int         HUB_FIFO_PHYSICAL_WIDTH_DEF = 64;
   localparam int         LINK_FIFO_DEPTH_DEF         = 4;
   localparam logic [1:0] DRAIN_HOLD_RELOAD           = 2'd2;
endpackage

// File: rtl/link_fifo.sv
// One direction of the link: DEPTH-word FIFO, 1-cycle push-to-pop latency.
// Backpressure: push_ready = !full from registered count only; pop side valid = !empty.
module link_fifo
   import hub_link_pkg::*;
#(
   parameter int WIDTH = HUB_FIFO_PHYSICAL_WIDTH_DEF,
   parameter int DEPTH = LINK_FIFO_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_valid,
   output logic             push_ready,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   input  logic             pop_ready
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_fire;
   logic             pop_fire;

   assign push_ready = (count != CNT_W'(DEPTH));
   assign pop_valid  = (count != '0);
   assign pop_data   = mem[rd_ptr];
   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = pop_valid && pop_ready;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_fire) wr_ptr <= wr_ptr + 1'b1;
         if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_fire, pop_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/hub_link_bridge.sv
// Hub<->leaf bridge: two link_fifo lanes (1-cycle latency, ready = !full) plus leaf status
// relay with drain-hold on message-flying; HUB_LINK_STATS_EN adds saturating word counters.
module hub_link_bridge
   import hub_link_pkg::*;
#(
   parameter int HUB_FIFO_PHYSICAL_WIDTH = HUB_FIFO_PHYSICAL_WIDTH_DEF,
   parameter int LINK_FIFO_DEPTH         = LINK_FIFO_DEPTH_DEF
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] hub_tx_data,
   input  logic                               hub_tx_valid,
   output logic                               hub_tx_ready,
   output logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] leaf_tx_data,
   output logic                               leaf_tx_valid,
   input  logic                               leaf_tx_ready,
   input  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] leaf_rx_data,
   input  logic                               leaf_rx_valid,
   output logic                               leaf_rx_ready,
   output logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] hub_rx_data,
   output logic                               hub_rx_valid,
   input  logic                               hub_rx_ready,
   input  logic                               leaf_has_message_flying,
   input  logic                               leaf_has_odd_clusters,
   output logic                               hub_has_message_flying,
   output logic                               hub_has_odd_clusters
`ifdef HUB_LINK_STATS_EN
   ,
   output logic [31:0]                        tx_word_count,
   output logic [31:0]                        rx_word_count
`endif
);
   logic [1:0] flag_ff;
   logic [1:0] drain_cnt;
   logic       busy;

   link_fifo #(.WIDTH(HUB_FIFO_PHYSICAL_WIDTH), .DEPTH(LINK_FIFO_DEPTH)) u_tx_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_data  (hub_tx_data),
      .push_valid (hub_tx_valid),
      .push_ready (hub_tx_ready),
      .pop_data   (leaf_tx_data),
      .pop_valid  (leaf_tx_valid),
      .pop_ready  (leaf_tx_ready)
   );

   link_fifo #(.WIDTH(HUB_FIFO_PHYSICAL_WIDTH), .DEPTH(LINK_FIFO_DEPTH)) u_rx_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_data  (leaf_rx_data),
      .push_valid (leaf_rx_valid),
      .push_ready (leaf_rx_ready),
      .pop_data   (hub_rx_data),
      .pop_valid  (hub_rx_valid),
      .pop_ready  (hub_rx_ready)
   );

   // Anything inside or arriving at the bridge keeps the hub from seeing quiescence.
   assign busy = flag_ff[0] | leaf_tx_valid | hub_rx_valid | hub_tx_valid | leaf_rx_valid;

   assign hub_has_message_flying = busy | (drain_cnt != 2'd0);
   assign hub_has_odd_clusters   = flag_ff[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_ff   <= 2'b00;
         drain_cnt <= 2'd0;
      end else begin
         flag_ff <= {leaf_has_odd_clusters, leaf_has_message_flying};
         if (busy)                  drain_cnt <= DRAIN_HOLD_RELOAD;
         else if (drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;
      end
   end

`ifdef HUB_LINK_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_word_count <= 32'd0;
         rx_word_count <= 32'd0;
      end else begin
         if (leaf_tx_valid && leaf_tx_ready && (tx_word_count != 32'hFFFF_FFFF))
            tx_word_count <= tx_word_count + 32'd1;
         if (hub_rx_valid && hub_rx_ready && (rx_word_count != 32'hFFFF_FFFF))
            rx_word_count <= rx_word_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hub_link_bridge.sv
// Directed bench for hub_link_bridge with per-direction scoreboards checked at each output transfer.
module tb_hub_link_bridge;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] hub_tx_data = '0;
   logic         hub_tx_valid = 1'b0;
   logic         hub_tx_ready;
   logic [W-1:0] leaf_tx_data;
   logic         leaf_tx_valid;
   logic         leaf_tx_ready = 1'b0;
   logic [W-1:0] leaf_rx_data = '0;
   logic         leaf_rx_valid = 1'b0;
   logic         leaf_rx_ready;
   logic [W-1:0] hub_rx_data;
   logic         hub_rx_valid;
   logic         hub_rx_ready = 1'b0;
   logic         leaf_has_message_flying = 1'b0;
   logic         leaf_has_odd_clusters = 1'b0;
   logic         hub_has_message_flying;
   logic         hub_has_odd_clusters;
`ifdef HUB_LINK_STATS_EN
   logic [31:0]  tx_word_count;
   logic [31:0]  rx_word_count;
`endif

   int checks = 0;
   int errors = 0;
   logic [W-1:0] tx_q[$];
   logic [W-1:0] rx_q[$];

   hub_link_bridge dut (
      .clk                    (clk),
      .reset                  (reset),
      .hub_tx_data            (hub_tx_data),
      .hub_tx_valid           (hub_tx_valid),
      .hub_tx_ready           (hub_tx_ready),
      .leaf_tx_data           (leaf_tx_data),
      .leaf_tx_valid          (leaf_tx_valid),
      .leaf_tx_ready          (leaf_tx_ready),
      .leaf_rx_data           (leaf_rx_data),
      .leaf_rx_valid          (leaf_rx_valid),
      .leaf_rx_ready          (leaf_rx_ready),
      .hub_rx_data            (hub_rx_data),
      .hub_rx_valid           (hub_rx_valid),
      .hub_rx_ready           (hub_rx_ready),
      .leaf_has_message_flying(leaf_has_message_flying),
      .leaf_has_odd_clusters  (leaf_has_odd_clusters),
      .hub_has_message_flying (hub_has_message_flying),
      .hub_has_odd_clusters   (hub_has_odd_clusters)
`ifdef HUB_LINK_STATS_EN
      ,
      .tx_word_count          (tx_word_count),
      .rx_word_count          (rx_word_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshakes are sampled mid-cycle; inputs change only just after posedge.
   always @(negedge clk) begin
      if (!reset) begin
         if (leaf_tx_valid && leaf_tx_ready) begin
            if (tx_q.size() == 0) check("tx_spurious_word", leaf_tx_data, 'x);
            else check("tx_data_order", leaf_tx_data, tx_q.pop_front());
         end
         if (hub_rx_valid && hub_rx_ready) begin
            if (rx_q.size() == 0) check("rx_spurious_word", hub_rx_data, 'x);
            else check("rx_data_order", hub_rx_data, rx_q.pop_front());
         end
         if (hub_tx_valid && hub_tx_ready) tx_q.push_back(hub_tx_data);
         if (leaf_rx_valid && leaf_rx_ready) rx_q.push_back(leaf_rx_data);
      end
   end

   initial begin
      // Reset state, during and after
      tick(); tick();
      check("rst_hub_tx_ready", W'(hub_tx_ready), 1);
      check("rst_leaf_rx_ready", W'(leaf_rx_ready), 1);
      check("rst_leaf_tx_valid", W'(leaf_tx_valid), 0);
      check("rst_hub_rx_valid", W'(hub_rx_valid), 0);
      check("rst_flying", W'(hub_has_message_flying), 0);
      check("rst_odd", W'(hub_has_odd_clusters), 0);
      reset = 1'b0;
      tick();
      check("post_rst_tx_ready", W'(hub_tx_ready), 1);
      check("post_rst_flying", W'(hub_has_message_flying), 0);

      // Single word, latency and drain-hold
      leaf_tx_ready = 1'b1;
      hub_tx_data   = 64'h0000_0000_DEAD_BEEF;
      hub_tx_valid  = 1'b1;
      #1 check("single_flying_push_cycle", W'(hub_has_message_flying), 1);
      tick();
      hub_tx_valid = 1'b0;
      check("single_valid_1cyc", W'(leaf_tx_valid), 1);
      check("single_data", leaf_tx_data, 64'h0000_0000_DEAD_BEEF);
      check("single_flying_in_fifo", W'(hub_has_message_flying), 1);
      tick();
      check("single_gone", W'(leaf_tx_valid), 0);
      check("single_flying_hold1", W'(hub_has_message_flying), 1);
      tick();
      check("single_flying_hold2", W'(hub_has_message_flying), 1);
      tick();
      check("single_flying_clear", W'(hub_has_message_flying), 0);

      // Fill to full, reject fifth word, drain in order
      leaf_tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("full_ready_before_push", W'(hub_tx_ready), 1);
         hub_tx_data  = 64'hA000_0000_0000_0000 | W'(i);
         hub_tx_valid = 1'b1;
         tick();
      end
      check("full_ready_low", W'(hub_tx_ready), 0);
      hub_tx_data = 64'hBAD0_0000_0000_0005;
      tick();
      hub_tx_valid = 1'b0;
      check("full_fifth_rejected", W'(dut.u_tx_fifo.count), 4);
      check("full_head_stable", leaf_tx_data, 64'hA000_0000_0000_0000);
      leaf_tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_valid_each_cycle", W'(leaf_tx_valid), 1);
         tick();
      end
      check("drain_empty", W'(leaf_tx_valid), 0);
      check("drain_all_seen", W'(tx_q.size()), 0);

      // Steady-state push+pop at occupancy 2
      leaf_tx_ready = 1'b0;
      hub_tx_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         hub_tx_data = 64'hC000_0000_0000_0000 | W'(i);
         tick();
      end
      leaf_tx_ready = 1'b1;
      for (int i = 2; i < 12; i++) begin
         hub_tx_data = 64'hC000_0000_0000_0000 | W'(i);
         tick();
         check("stream_occupancy", W'(dut.u_tx_fifo.count), 2);
      end
      hub_tx_valid = 1'b0;
      tick(); tick(); tick();
      check("stream_all_seen", W'(tx_q.size()), 0);

      // Status relay
      leaf_has_odd_clusters = 1'b1;
      #1 check("odd_before_edge", W'(hub_has_odd_clusters), 0);
      tick();
      check("odd_after_edge", W'(hub_has_odd_clusters), 1);
      leaf_has_message_flying = 1'b1;
      tick(); tick();
      check("leaf_flying_relay", W'(hub_has_message_flying), 1);
      leaf_has_message_flying = 1'b0;
      tick();
      check("leaf_flying_hold1", W'(hub_has_message_flying), 1);
      tick();
      check("leaf_flying_hold2", W'(hub_has_message_flying), 1);
      tick();
      check("leaf_flying_fall", W'(hub_has_message_flying), 0);
      leaf_has_odd_clusters = 1'b0;

      // Reset mid-burst with 3 words held in rx
      hub_rx_ready  = 1'b0;
      leaf_rx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         leaf_rx_data = 64'hD000_0000_0000_0000 | W'(i);
         tick();
      end
      leaf_rx_valid = 1'b0;
      check("rx_buffered_valid", W'(hub_rx_valid), 1);
      check("rx_buffered_head", hub_rx_data, 64'hD000_0000_0000_0000);
      reset = 1'b1;
      #1 check("rx_reset_valid_drop", W'(hub_rx_valid), 0);
      check("rx_reset_ready", W'(leaf_rx_ready), 1);
      rx_q.delete();
      tx_q.delete();
      hub_rx_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rx_no_stale", W'(hub_rx_valid), 0);
      end

      // Concurrent traffic both ways: 7 tx, 5 rx
      leaf_tx_ready = 1'b1;
      hub_rx_ready  = 1'b1;
      for (int i = 0; i < 7; i++) begin
         hub_tx_data   = 64'hE000_0000_0000_0000 | W'(i);
         hub_tx_valid  = 1'b1;
         leaf_rx_data  = 64'hF000_0000_0000_0000 | W'(i);
         leaf_rx_valid = (i < 5);
         tick();
      end
      hub_tx_valid  = 1'b0;
      leaf_rx_valid = 1'b0;
      tick(); tick(); tick();
      check("traffic_tx_seen", W'(tx_q.size()), 0);
      check("traffic_rx_seen", W'(rx_q.size()), 0);
`ifdef HUB_LINK_STATS_EN
      check("stats_tx_count", W'(tx_word_count), 7);
      check("stats_rx_count", W'(rx_word_count), 5);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
